// File: rtl/echo_pkg.sv
// Shared types and constants for the three-tap echo playback block.
// Holds the FSM state enum, RAM/tap timing constants and a saturator.
package echo_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_STROBE,
        TAP0,
        TAP1,
        TAP2,
        EMIT
    } state_t;

    localparam int RAM_LATENCY    = 2;
    localparam int TAP_CYCLES     = RAM_LATENCY + 1;
    localparam int DEF_TAP1_DELAY = 1500;
    localparam int DEF_TAP2_DELAY = 3000;

    function automatic logic signed [7:0] sat8(input logic signed [9:0] x);
        if (x > 10'sd127) begin
            return 8'sh7f;
        end else if (x < -10'sd128) begin
            return 8'sh80;
        end else begin
            return x[7:0];
        end
    endfunction

endpackage

// File: rtl/echo_mix.sv
// Combinational saturating mixer: tap0 + tap1/2 + tap2/4.
// Ports: tap0/tap1/tap2 signed 8-bit taps in, mix signed 8-bit out.
module echo_mix
    import echo_pkg::*;
(
    input  logic signed [7:0] tap0,
    input  logic signed [7:0] tap1,
    input  logic signed [7:0] tap2,
    output logic signed [7:0] mix
);

    logic signed [7:0] half;
    logic signed [7:0] quarter;
    logic signed [9:0] sum;

    // 10 bits cover the full range -224..221 without wrapping.
    always_comb begin
        half    = tap1 >>> 1;
        quarter = tap2 >>> 2;
        sum     = {{2{tap0[7]}}, tap0}
                + {{2{half[7]}}, half}
                + {{2{quarter[7]}}, quarter};
        mix     = sat8(sum);
    end

endmodule

// File: rtl/echo_player.sv
// Plays back an external sample buffer, mixing two delayed echo taps.
// Ports: clk_in/rst_in, strobe/play/loop/length controls, RAM read
// address/data, mixed sample out and busy/done/overrun status.
module echo_player
    import echo_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int TAP1_DELAY = DEF_TAP1_DELAY,
    parameter int TAP2_DELAY = DEF_TAP2_DELAY
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     audio_valid_in,
    input  logic                     play_in,
    input  logic                     loop_in,
    input  logic        [ADDR_W-1:0] length_in,
    output logic        [ADDR_W-1:0] rd_addr_out,
    input  logic signed [7:0]        rd_data_in,
    output logic signed [7:0]        sample_out,
    output logic                     sample_valid_out,
    output logic                     busy_out,
    output logic                     done_out,
    output logic                     overrun_out
);

    localparam logic [ADDR_W-1:0] D1 = ADDR_W'(TAP1_DELAY);
    localparam logic [ADDR_W-1:0] D2 = ADDR_W'(TAP2_DELAY);
    localparam logic [1:0] LAST_CNT  = 2'(TAP_CYCLES - 1);

    state_t             state;
    logic [ADDR_W-1:0]  pos;
    logic [ADDR_W-1:0]  len;
    logic [1:0]         cnt;
    logic signed [7:0]  tap0_q;
    logic signed [7:0]  tap1_q;
    logic               stop_q;

    logic               en1;
    logic               en2;
    logic               tap_done;
    logic               last;
    logic               in_sample;
    logic signed [7:0]  tap2_w;
    logic signed [7:0]  mix_w;

    // A tap reaching before the buffer start is silent, not wrapped.
    assign en1       = (pos >= D1);
    assign en2       = (pos >= D2);
    assign tap_done  = (cnt == LAST_CNT);
    assign last      = (pos == len - ADDR_W'(1));
    assign in_sample = (state != IDLE) && (state != WAIT_STROBE);
    assign tap2_w    = en2 ? rd_data_in : 8'sd0;

    echo_mix u_mix (
        .tap0 (tap0_q),
        .tap1 (tap1_q),
        .tap2 (tap2_w),
        .mix  (mix_w)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state            <= IDLE;
            pos              <= '0;
            len              <= '0;
            cnt              <= '0;
            tap0_q           <= '0;
            tap1_q           <= '0;
            stop_q           <= 1'b0;
            rd_addr_out      <= '0;
            sample_out       <= '0;
            sample_valid_out <= 1'b0;
            busy_out         <= 1'b0;
            done_out         <= 1'b0;
            overrun_out      <= 1'b0;
        end else begin
            sample_valid_out <= 1'b0;
            done_out         <= 1'b0;
            if (audio_valid_in && in_sample) begin
                overrun_out <= 1'b1;
            end
            // Remember a stop request; the sample in flight still finishes.
            if (!play_in && in_sample) begin
                stop_q <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (play_in && length_in != '0) begin
                        len      <= length_in;
                        pos      <= '0;
                        busy_out <= 1'b1;
                        state    <= WAIT_STROBE;
                    end
                end
                WAIT_STROBE: begin
                    if (!play_in) begin
                        pos      <= '0;
                        busy_out <= 1'b0;
                        state    <= IDLE;
                    end else if (audio_valid_in) begin
                        cnt         <= '0;
                        stop_q      <= 1'b0;
                        rd_addr_out <= pos;
                        state       <= TAP0;
                    end
                end
                TAP0: begin
                    if (tap_done) begin
                        tap0_q      <= rd_data_in;
                        cnt         <= '0;
                        rd_addr_out <= en1 ? pos - D1 : '0;
                        state       <= TAP1;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                TAP1: begin
                    if (tap_done) begin
                        tap1_q      <= en1 ? rd_data_in : 8'sd0;
                        cnt         <= '0;
                        rd_addr_out <= en2 ? pos - D2 : '0;
                        state       <= TAP2;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                TAP2: begin
                    if (tap_done) begin
                        sample_out       <= mix_w;
                        sample_valid_out <= 1'b1;
                        rd_addr_out      <= '0;
                        state            <= EMIT;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                EMIT: begin
                    if (stop_q || !play_in) begin
                        pos      <= '0;
                        busy_out <= 1'b0;
                        state    <= IDLE;
                    end else if (!last) begin
                        pos   <= pos + ADDR_W'(1);
                        state <= WAIT_STROBE;
                    end else if (loop_in) begin
                        pos   <= '0;
                        state <= WAIT_STROBE;
                    end else begin
                        pos      <= '0;
                        done_out <= 1'b1;
                        busy_out <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_echo_player.sv
// Directed self-checking bench for echo_player.
// Models a 2-cycle-latency buffer RAM and checks hand-computed samples.
module tb_echo_player;

    logic               clk_in = 1'b0;
    logic               rst_in;
    logic               audio_valid_in;
    logic               play_in;
    logic               loop_in;
    logic        [15:0] length_in;
    logic        [15:0] rd_addr_out;
    logic signed [7:0]  rd_data_in;
    logic signed [7:0]  sample_out;
    logic               sample_valid_out;
    logic               busy_out;
    logic               done_out;
    logic               overrun_out;

    logic signed [7:0]  mem [0:4095];
    logic signed [7:0]  d1;
    logic signed [7:0]  d2;

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;
    int done_cnt = 0;

    always #5 clk_in = ~clk_in;

    echo_player dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .audio_valid_in   (audio_valid_in),
        .play_in          (play_in),
        .loop_in          (loop_in),
        .length_in        (length_in),
        .rd_addr_out      (rd_addr_out),
        .rd_data_in       (rd_data_in),
        .sample_out       (sample_out),
        .sample_valid_out (sample_valid_out),
        .busy_out         (busy_out),
        .done_out         (done_out),
        .overrun_out      (overrun_out)
    );

    always @(posedge clk_in) begin
        d1 <= mem[rd_addr_out[11:0]];
        d2 <= d1;
    end
    assign rd_data_in = d2;

    always @(negedge clk_in) begin
        if (sample_valid_out) valid_cnt++;
        if (done_out) done_cnt++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk_in);
        #1;
    endtask

    task automatic fill_const(input int v);
        for (int i = 0; i < 4096; i++) mem[i] = 8'(v);
    endtask

    // Strobe once, then follow the sample cycle by cycle (k = cycles
    // after the strobe). Optional extra strobe / play drop / reset at k.
    task automatic play_sample(input int extra_k, input int drop_k,
                               input int rst_k, output int s,
                               output int lat, output int a0,
                               output int a1, output int a2);
        bit hit_rst;
        hit_rst = 1'b0;
        s = 0; lat = -1; a0 = -1; a1 = -1; a2 = -1;
        audio_valid_in = 1'b1;
        tick;
        audio_valid_in = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 1) a0 = int'(rd_addr_out);
            if (k == 4) a1 = int'(rd_addr_out);
            if (k == 7) a2 = int'(rd_addr_out);
            if (k == rst_k) begin
                rst_in = 1'b0;
                hit_rst = 1'b1;
                break;
            end
            if (sample_valid_out) begin
                lat = k;
                s = int'(sample_out);
                break;
            end
            if (k == drop_k) play_in = 1'b0;
            audio_valid_in = (k == extra_k);
            tick;
        end
        audio_valid_in = 1'b0;
        if (!hit_rst) tick;
    endtask

    int s, lat, a0, a1, a2, v0, d0, bad_lat;

    initial begin
        rst_in = 1'b0;
        audio_valid_in = 1'b0;
        play_in = 1'b0;
        loop_in = 1'b0;
        length_in = '0;
        fill_const(0);
        repeat (3) tick;
        chk("rst_addr", int'(rd_addr_out), 0);
        chk("rst_sample", int'(sample_out), 0);
        chk("rst_valid", int'(sample_valid_out), 0);
        chk("rst_busy", int'(busy_out), 0);
        chk("rst_done", int'(done_out), 0);
        chk("rst_overrun", int'(overrun_out), 0);
        rst_in = 1'b1;
        tick;

        // Ramp buffer, len 4, no loop.
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i % 128);
        length_in = 16'd4;
        play_in = 1'b1;
        tick;
        chk("ramp_busy", int'(busy_out), 1);
        for (int p = 0; p < 4; p++) begin
            play_sample(-1, -1, -1, s, lat, a0, a1, a2);
            if (p == 0) length_in = 16'd100;
            chk("ramp_sample", s, p);
            chk("ramp_lat", lat, 10);
            chk("ramp_a0", a0, p);
            if (p == 2) begin
                chk("ramp_a1_zero", a1, 0);
                chk("ramp_a2_zero", a2, 0);
            end
        end
        chk("ramp_done", int'(done_out), 1);
        chk("ramp_busy_end", int'(busy_out), 0);
        play_in = 1'b0;
        length_in = 16'd3;
        tick;

        // Loop mode, len 3.
        loop_in = 1'b1;
        play_in = 1'b1;
        d0 = done_cnt;
        tick;
        for (int n = 0; n < 7; n++) begin
            play_sample(-1, -1, -1, s, lat, a0, a1, a2);
            chk("loop_sample", s, n % 3);
        end
        chk("loop_no_done", done_cnt - d0, 0);
        chk("loop_busy", int'(busy_out), 1);
        play_in = 1'b0;
        loop_in = 1'b0;
        repeat (2) tick;

        // play_in dropped mid-sample.
        length_in = 16'd4;
        play_in = 1'b1;
        d0 = done_cnt;
        tick;
        play_sample(-1, -1, -1, s, lat, a0, a1, a2);
        chk("stop_first", s, 0);
        play_sample(-1, 3, -1, s, lat, a0, a1, a2);
        chk("stop_sample", s, 1);
        chk("stop_lat", lat, 10);
        chk("stop_busy", int'(busy_out), 0);
        chk("stop_no_done", done_cnt - d0, 0);
        play_in = 1'b1;
        tick;
        play_sample(-1, -1, -1, s, lat, a0, a1, a2);
        chk("stop_restart_p0", a0, 0);
        chk("stop_restart_s", s, 0);
        play_in = 1'b0;
        repeat (2) tick;

        // Overrun: second strobe 5 cycles into a sample.
        chk("ovr_clear", int'(overrun_out), 0);
        play_in = 1'b1;
        tick;
        v0 = valid_cnt;
        play_sample(5, -1, -1, s, lat, a0, a1, a2);
        chk("ovr_lat", lat, 10);
        repeat (5) tick;
        chk("ovr_pulses", valid_cnt - v0, 1);
        chk("ovr_flag", int'(overrun_out), 1);

        // Reset 6 cycles into a sample.
        play_sample(-1, -1, 6, s, lat, a0, a1, a2);
        #1;
        chk("mid_rst_addr", int'(rd_addr_out), 0);
        chk("mid_rst_sample", int'(sample_out), 0);
        chk("mid_rst_busy", int'(busy_out), 0);
        chk("mid_rst_overrun", int'(overrun_out), 0);
        tick;
        rst_in = 1'b1;
        v0 = valid_cnt;
        d0 = done_cnt;
        repeat (20) tick;
        chk("mid_rst_no_valid", valid_cnt - v0, 0);
        chk("mid_rst_no_done", done_cnt - d0, 0);
        play_in = 1'b0;
        repeat (2) tick;

        // Long run through the echo offsets.
        fill_const(-128);
        length_in = 16'd3003;
        play_in = 1'b1;
        bad_lat = 0;
        tick;
        for (int p = 0; p < 3003; p++) begin
            if (p == 1601) begin
                fill_const(0);
                mem[4095] = 8'sd64;
                mem[1700] = 8'sd10;
                mem[200]  = 8'sd20;
                mem[2999] = 8'sd4;
                mem[1499] = 8'sd8;
                mem[3000] = 8'sd100;
                mem[1500] = 8'sd100;
                mem[0]    = 8'sd100;
                mem[3001] = -8'sd3;
                mem[1501] = -8'sd7;
                mem[1]    = -8'sd9;
            end
            if (p == 3002) fill_const(-128);
            play_sample(-1, -1, -1, s, lat, a0, a1, a2);
            if (lat != 10) bad_lat++;
            unique case (p)
                100:  chk("p100_tap0_only", s, -128);
                1500: begin
                    chk("p1500_sat", s, -128);
                    chk("p1500_a1", a1, 0);
                end
                1600: begin
                    chk("p1600_sat", s, -128);
                    chk("p1600_a1", a1, 100);
                end
                1700: begin
                    chk("p1700_mix", s, 20);
                    chk("p1700_a1", a1, 200);
                end
                2999: begin
                    chk("p2999_mix", s, 8);
                    chk("p2999_a2", a2, 0);
                end
                3000: begin
                    chk("p3000_sat_hi", s, 127);
                    chk("p3000_a1", a1, 1500);
                    chk("p3000_a2", a2, 0);
                end
                3001: begin
                    chk("p3001_shifts", s, -10);
                    chk("p3001_a2", a2, 1);
                end
                3002: chk("p3002_sat_lo", s, -128);
                default: ;
            endcase
        end
        chk("long_latency", bad_lat, 0);
        chk("long_done", int'(done_out), 1);
        play_in = 1'b0;
        repeat (2) tick;

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/echo_player.md
ECHO_PLAYER -- requirements
Module: echo_player

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, width of buffer address and length.
REQ-002 The block SHALL have parameter TAP1_DELAY, default 1500, first echo offset in samples.
REQ-003 The block SHALL have parameter TAP2_DELAY, default 3000, second echo offset in samples.
REQ-004 The block SHALL have port clk_in  input  1  sole clock, all logic on rising edge.
REQ-005 The block SHALL have port rst_in  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port audio_valid_in  input  1  one-cycle sample-rate strobe.
REQ-007 The block SHALL have port play_in  input  1  level; high requests playback.
REQ-008 The block SHALL have port loop_in  input  1  level; high wraps at end of buffer.
REQ-009 The block SHALL have port length_in  input  ADDR_W  number of valid recorded samples.
REQ-010 The block SHALL have port rd_addr_out  output  ADDR_W  buffer read address.
REQ-011 The block SHALL have port rd_data_in  input  8 signed  buffer read data, valid 2 cycles after address.
REQ-012 The block SHALL have port sample_out  output  8 signed  mixed playback sample.
REQ-013 The block SHALL have port sample_valid_out  output  1  one-cycle pulse, sample_out new.
REQ-014 The block SHALL have ports busy_out, done_out (pulse), overrun_out (sticky), each output 1 bit.

Function
REQ-015 States SHALL be IDLE, WAIT_STROBE, TAP0, TAP1, TAP2, EMIT; IDLE->WAIT_STROBE when play_in=1 and length_in!=0, latching length_in and setting position p=0.
REQ-016 In WAIT_STROBE an audio_valid_in pulse (cycle 0) SHALL enter TAP0; no strobe means remain.
REQ-017 Each TAPk state SHALL last exactly 3 cycles: drive rd_addr_out on its first cycle, capture rd_data_in on its third; TAP0 address p, TAP1 p-TAP1_DELAY, TAP2 p-TAP2_DELAY.
REQ-018 A tap whose offset exceeds p SHALL contribute 0 and drive rd_addr_out=0, never a wrapped address.
REQ-019 Mix SHALL be tap0 + (tap1>>>1) + (tap2>>>2), arithmetic shifts, computed in 10-bit signed, saturated to [-128,127].
REQ-020 sample_out and sample_valid_out SHALL update in EMIT, cycle 10 after the strobe; fixed latency 10 cycles.
REQ-021 After EMIT: p<len-1 -> p+1, WAIT_STROBE; p=len-1 and loop_in=1 -> p=0, WAIT_STROBE; p=len-1 and loop_in=0 -> done_out pulse, IDLE.
REQ-022 play_in low observed during a sample SHALL let that sample complete through EMIT, then IDLE with p=0, no done_out.
REQ-023 A strobe arriving in TAP0..EMIT SHALL be dropped and set overrun_out, cleared only by reset.
REQ-024 busy_out SHALL be 1 in every state except IDLE; length_in changes during playback SHALL be ignored.
REQ-025 sample_out SHALL hold its last value between pulses; rd_addr_out SHALL be 0 in IDLE and WAIT_STROBE.

Reset
REQ-026 rst_in low SHALL asynchronously force IDLE, p=0, latched length=0, all tap registers 0, and every output 0.
REQ-027 Reset mid-sample SHALL produce no sample_valid_out or done_out pulse after release.

Structure
REQ-028 Package echo_pkg SHALL hold the state enum, RAM_LATENCY=2, TAP_CYCLES=3, and the default tap delays.
REQ-029 Saturating three-tap mixer SHALL be a combinational sub-module echo_mix; the buffer RAM stays outside the block.

Verification
REQ-030 Buffer ramp mem[i]=i mod 128, len=4, loop=0, 4 strobes -> samples 0,1,2,3 (taps zero), then done_out, busy_out=0.
REQ-031 mem[3000]=100, mem[1500]=100, mem[0]=100, p=3000 -> sample_out=100+50+25=175 saturated to 127.
REQ-032 mem all -128, p>=3000 -> sum -224 saturated to -128; p=1600 -> -128+(-64)=-192 -> -128.
REQ-033 len=3, loop=1, 7 strobes -> positions 0,1,2,0,1,2,0, no done_out.
REQ-034 Strobe at cycle 0 and again at cycle 5 -> one sample_valid_out at cycle 10, overrun_out=1.
REQ-035 rst_in low at cycle 6 of a sample -> all outputs 0 immediately, no pulse after release; play_in low mid-sample -> sample emitted, then IDLE.
